// File: rtl/adder_multicycle_ctrl_if.sv
// Handshake and adder-bus signals for adder_multicycle_ctrl.
// The slave modport is the controller's view; the master modport is the environment's view.
interface adder_multicycle_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_acc;
    logic             acc_clr;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] add_s;
    logic             add_cout;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_acc, acc_clr,
        output in_ready,
        output add_a, add_b, add_cin,
        input  add_s, add_cout,
        output out_valid, out_sum, out_cout, out_ovf,
        input  out_ready
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, in_acc, acc_clr,
        input  in_ready,
        input  add_a, add_b, add_cin,
        output add_s, add_cout,
        input  out_valid, out_sum, out_cout, out_ovf,
        output out_ready
    );
endinterface

// File: rtl/adder_multicycle_ctrl.sv
// Sequencer around a ripple-carry adder: registers operands, holds them for
// SETTLE_CYCLES so the carry chain is a multicycle path, then captures the result.
module adder_multicycle_ctrl #(
    parameter int unsigned WIDTH         = 32,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input logic                     clk,
    input logic                     rst_n,
    adder_multicycle_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_e;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] add_a_q, add_a_d;
    logic [WIDTH-1:0] add_b_q, add_b_d;
    logic             add_cin_q, add_cin_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             ovf_calc;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        add_a_d   = add_a_q;
        add_b_d   = add_b_q;
        add_cin_d = add_cin_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;
        acc_d     = acc_q;
        // Sign test uses only the operands, never the carry-in
        ovf_calc  = (add_a_q[WIDTH-1] == add_b_q[WIDTH-1]) &&
                    (bus.add_s[WIDTH-1] != add_a_q[WIDTH-1]);
        case (state_q)
            IDLE: begin
                if (bus.acc_clr) acc_d = '0;
                if (bus.in_valid) begin
                    add_a_d   = bus.in_acc ? (bus.acc_clr ? '0 : acc_q) : bus.in_a;
                    add_b_d   = bus.in_b;
                    add_cin_d = bus.in_cin;
                    cnt_d     = CNT_INIT;
                    state_d   = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    sum_d   = bus.add_s;
                    cout_d  = bus.add_cout;
                    ovf_d   = ovf_calc;
                    acc_d   = bus.add_s;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.acc_clr) acc_d = '0;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            add_a_q   <= '0;
            add_b_q   <= '0;
            add_cin_q <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
            acc_q     <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            add_a_q   <= add_a_d;
            add_b_q   <= add_b_d;
            add_cin_q <= add_cin_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            ovf_q     <= ovf_d;
            acc_q     <= acc_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.add_a     = add_a_q;
    assign bus.add_b     = add_b_q;
    assign bus.add_cin   = add_cin_q;
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_q;
    assign bus.out_ovf   = ovf_q;
endmodule

// File: tb/tb_adder_multicycle_ctrl.sv
// Randomised and directed bench for adder_multicycle_ctrl against an arithmetic reference model.
module tb_adder_multicycle_ctrl;
    localparam int W = 32;
    localparam int S = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;
    logic [W-1:0] acc_m = '0;

    always #5 clk = ~clk;

    adder_multicycle_ctrl_if #(.WIDTH(W)) bus ();

    // Behavioural adder hooked to the controller's adder bus
    assign {bus.add_cout, bus.add_s} = 33'(bus.add_a) + 33'(bus.add_b) + 33'(bus.add_cin);

    adder_multicycle_ctrl #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference: operand selection, 33-bit unsigned sum, signed range test without carry-in
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic acc, input logic clr,
                         output logic [W-1:0] ea, output logic [W-1:0] es,
                         output logic ec, output logic eo);
        longint unsigned u;
        longint          sg;
        if (clr) acc_m = '0;
        ea = acc ? acc_m : a;
        u  = longint'(ea) + longint'(b) + longint'(cin);
        sg = longint'($signed(ea)) + longint'($signed(b));
        es = u[W-1:0];
        ec = (u >= 64'h1_0000_0000);
        eo = (sg > 64'sd2147483647) || (sg < -64'sd2147483648);
        acc_m = es;
    endtask

    // Issues one transaction and waits for out_valid; leaves the result unconsumed
    task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                           input logic acc, input logic clr,
                           output logic [W-1:0] oa, output logic [W-1:0] sum,
                           output logic cout, output logic ovf,
                           output int lat, output bit stable, output bit busy);
        logic [W-1:0] sa, sb;
        logic         sc;
        bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_cin = cin;
        bus.in_acc = acc; bus.acc_clr = clr;
        @(posedge clk); #1;
        bus.acc_clr = 1'b0;
        oa = bus.add_a; sa = bus.add_a; sb = bus.add_b; sc = bus.add_cin;
        stable = 1'b1; busy = 1'b1; lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            bus.in_valid = 1'($urandom); bus.in_a = $urandom; bus.in_b = $urandom;
            bus.in_acc = 1'($urandom); bus.in_cin = 1'($urandom);
            if (bus.in_ready !== 1'b0) busy = 1'b0;
            @(posedge clk); #1;
            lat++;
            if (bus.add_a !== sa || bus.add_b !== sb || bus.add_cin !== sc) stable = 1'b0;
        end
        bus.in_valid = 1'b0;
        sum = bus.out_sum; cout = bus.out_cout; ovf = bus.out_ovf;
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        acc_m = '0;
        n_vec++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid);
        end
        n_vec++;
        if (bus.add_a !== '0 || bus.add_b !== '0 || bus.add_cin !== 1'b0 ||
            bus.out_sum !== '0 || bus.out_cout !== 1'b0 || bus.out_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL reset_regs: add_a=%h add_b=%h cin=%b sum=%h cout=%b ovf=%b required all 0",
                     bus.add_a, bus.add_b, bus.add_cin, bus.out_sum, bus.out_cout, bus.out_ovf);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [4] = '{32'h5, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
        logic [W-1:0] tb [4] = '{32'h3, 32'h0, 32'h1, 32'h8000_0000};
        logic         tc [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [W-1:0] ea, es, oa, sum;
        logic ec, eo, cout, ovf;
        int lat; bit stable, busy;
        for (int i = 0; i < 4; i++) begin
            model(ta[i], tb[i], tc[i], 1'b0, 1'b0, ea, es, ec, eo);
            run_txn(ta[i], tb[i], tc[i], 1'b0, 1'b0, oa, sum, cout, ovf, lat, stable, busy);
            n_vec++;
            if (oa !== ea) begin
                n_err++; $display("FAIL dir%0d_add_a: got %h required %h", i, oa, ea);
            end
            n_vec++;
            if (lat !== S) begin
                n_err++; $display("FAIL dir%0d_latency: got %0d required %0d", i, lat, S);
            end
            n_vec++;
            if (!stable || !busy) begin
                n_err++; $display("FAIL dir%0d_settle: stable=%b in_ready_low=%b required 1/1", i, stable, busy);
            end
            n_vec++;
            if (sum !== es || cout !== ec || ovf !== eo) begin
                n_err++;
                $display("FAIL dir%0d_result: sum=%h cout=%b ovf=%b required %h %b %b", i, sum, cout, ovf, es, ec, eo);
            end
            consume();
        end
    endtask

    task automatic test_accumulate();
        logic [W-1:0] bs [4] = '{32'd10, 32'd20, 32'd30, 32'd7};
        logic [W-1:0] req [4] = '{32'd10, 32'd30, 32'd60, 32'd7};
        logic [W-1:0] ea, es, oa, sum;
        logic ec, eo, cout, ovf;
        int lat; bit stable, busy;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                bus.acc_clr = 1'b1;
                @(posedge clk); #1;
                bus.acc_clr = 1'b0;
                acc_m = '0;
            end
            model($urandom, bs[i], 1'b0, 1'b1, i == 0, ea, es, ec, eo);
            run_txn($urandom, bs[i], 1'b0, 1'b1, i == 0, oa, sum, cout, ovf, lat, stable, busy);
            n_vec++;
            if (sum !== req[i] || sum !== es) begin
                n_err++; $display("FAIL acc%0d_sum: got %0d required %0d", i, sum, req[i]);
            end
            consume();
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, ea, es, oa, sum;
        logic cin, acc, clr, ec, eo, cout, ovf;
        int lat; bit stable, busy;
        for (int i = 0; i < 30; i++) begin
            a = $urandom; b = (i % 3 == 0) ? ~a : $urandom;
            cin = 1'($urandom); acc = 1'($urandom); clr = ($urandom_range(0, 5) == 0);
            model(a, b, cin, acc, clr, ea, es, ec, eo);
            run_txn(a, b, cin, acc, clr, oa, sum, cout, ovf, lat, stable, busy);
            n_vec++;
            if (oa !== ea || lat !== S || !stable || !busy ||
                sum !== es || cout !== ec || ovf !== eo) begin
                n_err++;
                $display("FAIL rnd%0d: add_a=%h lat=%0d stable=%b busy=%b sum=%h cout=%b ovf=%b required %h %0d 1 1 %h %b %b",
                         i, oa, lat, stable, busy, sum, cout, ovf, ea, S, es, ec, eo);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
            consume();
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] ea, es, oa, sum;
        logic ec, eo, cout, ovf;
        int lat; bit stable, busy, held;
        model(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 1'b0, ea, es, ec, eo);
        run_txn(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 1'b0, oa, sum, cout, ovf, lat, stable, busy);
        held = 1'b1;
        bus.in_valid = 1'b1; bus.in_a = 32'hDEAD_BEEF; bus.in_b = 32'h1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_sum !== es ||
                bus.out_cout !== ec || bus.out_ovf !== eo || bus.add_a !== ea) held = 1'b0;
        end
        bus.in_valid = 1'b0;
        n_vec++;
        if (!held) begin
            n_err++; $display("FAIL bp_hold: result not held under backpressure, required sum %h", es);
        end
        consume();
        n_vec++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] ea, es, oa, sum;
        logic ec, eo, cout, ovf;
        int lat; bit stable, busy, stale;
        for (int phase = 0; phase < 2; phase++) begin
            if (phase == 0) begin
                bus.in_valid = 1'b1; bus.in_a = 32'hAAAA_0001; bus.in_b = 32'h5555_0002; bus.in_cin = 1'b1;
                bus.in_acc = 1'b0;
                @(posedge clk); #1;
                bus.in_valid = 1'b0;
            end else begin
                run_txn(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, oa, sum, cout, ovf, lat, stable, busy);
            end
            rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            acc_m = '0;
            n_vec++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.add_a !== '0 || bus.add_b !== '0 ||
                bus.add_cin !== 1'b0 || bus.out_sum !== '0 || bus.out_cout !== 1'b0 || bus.out_ovf !== 1'b0) begin
                n_err++;
                $display("FAIL rstmid%0d_regs: out_valid=%b in_ready=%b add_a=%h sum=%h required 0 1 0 0",
                         phase, bus.out_valid, bus.in_ready, bus.add_a, bus.out_sum);
            end
            stale = 1'b0;
            repeat (S + 3) begin
                @(posedge clk); #1;
                if (bus.out_valid !== 1'b0) stale = 1'b1;
            end
            n_vec++;
            if (stale) begin
                n_err++; $display("FAIL rstmid%0d_stale: out_valid rose after reset, required 0", phase);
            end
            model(32'h0, 32'd5, 1'b0, 1'b1, 1'b0, ea, es, ec, eo);
            run_txn(32'hFFFF_0000, 32'd5, 1'b0, 1'b1, 1'b0, oa, sum, cout, ovf, lat, stable, busy);
            n_vec++;
            if (sum !== es || oa !== '0) begin
                n_err++; $display("FAIL rstmid%0d_acc: sum=%h add_a=%h required %h 0", phase, sum, oa, es);
            end
            consume();
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_cin = 1'b0;
        bus.in_acc = 1'b0; bus.acc_clr = 1'b0; bus.out_ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_directed();
        test_accumulate();
        test_random();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/adder_multicycle_ctrl.md
Name: adder_multicycle_ctrl

Overview:
- Sequencing stage wrapped around the 32-bit ripple-carry adder.
- Accepts operand transactions over a valid/ready handshake and registers them onto the adder inputs.
- Holds those inputs stable for a parameterised number of settle cycles, which makes the full carry chain a declared multicycle path.
- Captures sum, carry-out and signed overflow into an output register with its own valid/ready handshake, and keeps a running accumulator so results can be chained.

Parameters:
- WIDTH, 32, operand/sum width; must match the adder instance.
- SETTLE_CYCLES, 2, cycles adder inputs are held before the result is sampled; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operand transaction present.
- in_ready  output  1  block can accept a transaction.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry-in.
- in_acc  input  1  use accumulator value instead of in_a as operand A.
- acc_clr  input  1  clear accumulator.
- add_a  output  WIDTH  registered operand A to adder.
- add_b  output  WIDTH  registered operand B to adder.
- add_cin  output  1  registered carry-in to adder.
- add_s  input  WIDTH  adder sum.
- add_cout  input  1  adder carry-out.
- out_valid  output  1  result register holds unconsumed result.
- out_ready  input  1  consumer accepts result.
- out_sum  output  WIDTH  captured sum.
- out_cout  output  1  captured carry-out.
- out_ovf  output  1  captured signed (two's-complement) overflow.

Behaviour:
- Decided: one clock, clk; reset is rst_n, synchronous and active-low.
- Reset (rst_n=0 at a rising edge): state=IDLE. add_a, add_b, add_cin, out_sum, out_cout, out_ovf, the accumulator and the settle counter all go to 0. out_valid=0, in_ready=1 in the next cycle.
- Reset mid-operation (SETTLE or DONE): the in-flight or unconsumed result is discarded. No partial result is ever presented.
- State IDLE:
  - in_ready=1, out_valid=0.
  - Accept when in_valid=1 at an edge.
  - On accept: add_a <= (in_acc ? acc : in_a), add_b <= in_b, add_cin <= in_cin, counter <= SETTLE_CYCLES-1, state <= SETTLE.
- State SETTLE:
  - in_ready=0, out_valid=0.
  - add_* outputs are held constant.
  - Each edge: if counter != 0, decrement; else capture and go to DONE.
  - Capture: out_sum <= add_s, out_cout <= add_cout, out_ovf <= (add_a[WIDTH-1]==add_b[WIDTH-1]) && (add_s[WIDTH-1]!=add_a[WIDTH-1]), acc <= add_s.
- State DONE:
  - out_valid=1, in_ready=0. Outputs are stable until consumed.
  - On out_valid && out_ready at an edge: state <= IDLE.
  - No same-cycle re-accept; maximum throughput is one transaction per SETTLE_CYCLES+2 cycles.
- Latency: accept at edge E; capture at edge E+SETTLE_CYCLES; out_valid=1 from that edge onward.
- add_a/add_b/add_cin change only at an accept edge or at reset. out_sum/out_cout/out_ovf change only at a capture edge or at reset.
- acc_clr:
  - Acts at any edge in IDLE or DONE: acc <= 0.
  - If coincident with an accept that has in_acc=1, operand A is 0.
  - Ignored in SETTLE, so capture always wins.
- Carry-out is unsigned overflow; out_ovf ignores add_cin for the sign test. Both are reported independently.
- in_* inputs are don't-care while in_ready=0.
- out_ready is don't-care while out_valid=0.

Test Plan:
- Reset then single add: a=0x0000_0005, b=0x0000_0003, cin=0 accepted at edge E. Expect add_a=5 from E; out_valid rises at E+2 (SETTLE_CYCLES=2); out_sum=0x8, cout=0, ovf=0.
- Full carry ripple: a=0xFFFF_FFFF, b=0x0000_0000, cin=1. Expect out_sum=0x0, cout=1, ovf=0. add_* must stay stable through all SETTLE cycles.
- Signed overflow: a=0x7FFF_FFFF, b=0x0000_0001, cin=0. Expect sum=0x8000_0000, cout=0, ovf=1. Then a=0x8000_0000, b=0x8000_0000: expect sum=0, cout=1, ovf=1.
- Accumulate chain: with acc_clr pulsed, issue b=10, then b=20, then b=30, each with in_acc=1. Expect out_sum 10, 30, 60. Pulse acc_clr in IDLE, then in_acc=1, b=7: expect 7.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. Expect out_valid held, outputs constant, in_ready=0, and in_valid ignored. Release out_ready: IDLE next cycle, in_ready=1.
- Reset mid-operation: assert rst_n=0 during SETTLE, then during DONE. Expect out_valid=0 and all outputs and acc 0 after that edge, with no stale result presented after reset release.
